// File: rtl/line_fill_responder.sv
// Memory-side responder for the set-associative cache miss path: serves line fills and
// dirty-line writebacks as fixed-length bursts against a word-addressed backing store.
module line_fill_responder #(
  parameter int LINE_SIZE_BYTES = 64,
  parameter int DATA_WIDTH      = 32,
  parameter int TAG_BITS        = 18,
  parameter int INDEX_WIDTH     = 8,
  parameter int OFFSET_WIDTH    = 6,
  parameter int MEM_WORDS       = 4096,
  parameter int READ_LATENCY    = 4
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             i_req_valid,
  output logic                                             o_req_ready,
  input  logic                                             i_req_write,
  input  logic [TAG_BITS+INDEX_WIDTH+OFFSET_WIDTH-1:0]     i_req_address,
  input  logic                                             i_wdata_valid,
  output logic                                             o_wdata_ready,
  input  logic [DATA_WIDTH-1:0]                            i_wdata,
  output logic                                             o_rdata_valid,
  input  logic                                             i_rdata_ready,
  output logic [DATA_WIDTH-1:0]                            o_rdata,
  output logic                                             o_rdata_last,
  output logic                                             o_wr_done,
  output logic                                             o_busy
);

  localparam int ADDRESS_WIDTH = TAG_BITS + INDEX_WIDTH + OFFSET_WIDTH;
  localparam int BEATS         = LINE_SIZE_BYTES * 8 / DATA_WIDTH;
  localparam int BEAT_W        = $clog2(BEATS);
  localparam int LAT_W         = $clog2(READ_LATENCY + 1);
  localparam int MEM_AW        = $clog2(MEM_WORDS);
  localparam int LINE_W        = ADDRESS_WIDTH - OFFSET_WIDTH;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_BURST = 3'd2,
    WR_BURST = 3'd3,
    WR_ACK   = 3'd4
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [LINE_W-1:0]       line_r;
  logic [BEAT_W-1:0]       beat_r;
  logic [LAT_W-1:0]        lat_r;
  logic [DATA_WIDTH-1:0]   rdata_r;
  logic [DATA_WIDTH-1:0]   mem_r [MEM_WORDS];
  logic                    last_beat_s;
  logic                    rd_hs_s;
  logic                    wr_beat_s;
  logic                    unused_offset_s;

  // Word select: line number concatenated with the beat, truncated to the store depth.
  function automatic logic [MEM_AW-1:0] word_index(input logic [LINE_W-1:0] line,
                                                   input logic [BEAT_W-1:0] beat);
    logic [LINE_W+BEAT_W-1:0] full;
    full = {line, beat};
    return full[MEM_AW-1:0];
  endfunction

  assign unused_offset_s = ^i_req_address[OFFSET_WIDTH-1:0];
  assign last_beat_s     = (beat_r == BEAT_W'(BEATS - 1));
  assign rd_hs_s         = (state_r == RD_BURST) & i_rdata_ready;
  assign wr_beat_s       = (state_r == WR_BURST) & i_wdata_valid;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_req_valid) begin
          state_nxt_s = i_req_write ? WR_BURST : RD_WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_WAIT: begin
        if (lat_r == LAT_W'(0)) begin
          state_nxt_s = RD_BURST;
        end else begin
          state_nxt_s = RD_WAIT;
        end
      end
      RD_BURST: begin
        if (rd_hs_s && last_beat_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RD_BURST;
        end
      end
      WR_BURST: begin
        if (wr_beat_s && last_beat_s) begin
          state_nxt_s = WR_ACK;
        end else begin
          state_nxt_s = WR_BURST;
        end
      end
      WR_ACK:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Request latch, beat/latency counters and the read-data register.
  // rdata_r is prefetched for the next beat on each handshake so beats stream without bubbles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      line_r  <= '0;
      beat_r  <= '0;
      lat_r   <= '0;
      rdata_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_req_valid) begin
            line_r <= i_req_address[ADDRESS_WIDTH-1:OFFSET_WIDTH];
            beat_r <= '0;
            lat_r  <= LAT_W'(READ_LATENCY - 1);
          end
        end
        RD_WAIT: begin
          if (lat_r == LAT_W'(0)) begin
            rdata_r <= mem_r[word_index(line_r, BEAT_W'(0))];
          end else begin
            lat_r <= lat_r - LAT_W'(1);
          end
        end
        RD_BURST: begin
          if (rd_hs_s && !last_beat_s) begin
            beat_r  <= beat_r + BEAT_W'(1);
            rdata_r <= mem_r[word_index(line_r, beat_r + BEAT_W'(1))];
          end
        end
        WR_BURST: begin
          if (wr_beat_s) begin
            beat_r <= beat_r + BEAT_W'(1);
          end
        end
        default: begin
          beat_r <= beat_r;
        end
      endcase
    end
  end

  // Backing store write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (rst && wr_beat_s) begin
      mem_r[word_index(line_r, beat_r)] <= i_wdata;
    end
  end

  assign o_req_ready   = (state_r == IDLE)     & rst;
  assign o_busy        = (state_r != IDLE)     & rst;
  assign o_rdata_valid = (state_r == RD_BURST) & rst;
  assign o_rdata_last  = o_rdata_valid & last_beat_s;
  assign o_wdata_ready = (state_r == WR_BURST) & rst;
  assign o_wr_done     = (state_r == WR_ACK)   & rst;
  assign o_rdata       = rst ? rdata_r : '0;

endmodule

// File: tb/tb_line_fill_responder.sv
// Directed bench for line_fill_responder: a bench-side memory model feeds a queue of
// expected fill beats that is drained and compared on every read handshake.
module tb_line_fill_responder;

  localparam int READ_LATENCY = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_write;
  logic [31:0] i_req_address;
  logic        i_wdata_valid;
  logic        o_wdata_ready;
  logic [31:0] i_wdata;
  logic        o_rdata_valid;
  logic        i_rdata_ready;
  logic [31:0] o_rdata;
  logic        o_rdata_last;
  logic        o_wr_done;
  logic        o_busy;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mem [4096];
  logic [32:0] exp_q [$];

  always #5 clk = ~clk;

  line_fill_responder #(.READ_LATENCY(READ_LATENCY)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_write(i_req_write), .i_req_address(i_req_address),
    .i_wdata_valid(i_wdata_valid), .o_wdata_ready(o_wdata_ready), .i_wdata(i_wdata),
    .o_rdata_valid(o_rdata_valid), .i_rdata_ready(i_rdata_ready),
    .o_rdata(o_rdata), .o_rdata_last(o_rdata_last),
    .o_wr_done(o_wr_done), .o_busy(o_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] widx(input logic [31:0] a, input int k);
    logic [3:0] kb;
    kb = k[3:0];
    return {a[13:6], kb};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_fill(input logic [31:0] a);
    logic l;
    i_req_valid   = 1'b1;
    i_req_write   = 1'b0;
    i_req_address = a;
    for (int k = 0; k < 16; k++) begin
      l = (k == 15);
      exp_q.push_back({l, model_mem[widx(a, k)]});
    end
  endtask

  // Full writeback; gap_at inserts one invalid cycle carrying junk data before that beat.
  task automatic write_line(input logic [31:0] a, input logic [31:0] d0, input int gap_at);
    @(negedge clk);
    chk("wr_req_ready", o_req_ready, 32'd1);
    i_req_valid   = 1'b1;
    i_req_write   = 1'b1;
    i_req_address = a;
    step();
    i_req_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == gap_at) begin
        i_wdata_valid = 1'b0;
        i_wdata       = 32'hDEAD_BEEF;
        step();
      end
      i_wdata_valid = 1'b1;
      i_wdata       = d0 + k;
      model_mem[widx(a, k)] = d0 + k;
      if (k == 0) begin
        @(negedge clk);
        chk("wdata_ready", o_wdata_ready, 32'd1);
      end
      step();
    end
    i_wdata_valid = 1'b0;
    @(negedge clk);
    chk("wr_done_pulse", o_wr_done, 32'd1);
    chk("wdata_ready_ack", o_wdata_ready, 32'd0);
    step();
    @(negedge clk);
    chk("wr_done_once", o_wr_done, 32'd0);
    chk("req_ready_after_wr", o_req_ready, 32'd1);
  endtask

  // Drains one fill; entered #1 after the accept edge. pat[i%4] drives i_rdata_ready.
  task automatic collect(input logic [3:0] pat, input logic chk_lat, input logic held_req);
    int          hs      = 0;
    int          first   = -1;
    logic        stalled = 1'b0;
    logic [31:0] held_d  = '0;
    logic        held_l  = 1'b0;
    logic [32:0] e;
    for (int i = 0; i < 200 && hs < 16; i++) begin
      i_rdata_ready = pat[i % 4];
      @(negedge clk);
      chk("busy", o_busy, 32'd1);
      if (held_req) chk("req_ready_while_busy", o_req_ready, 32'd0);
      if (o_rdata_valid) begin
        if (first < 0) begin
          first = i;
          if (chk_lat) chk("first_valid_latency", first, READ_LATENCY);
        end
        if (stalled) begin
          chk("stall_hold_data", o_rdata, held_d);
          chk("stall_hold_last", o_rdata_last, held_l);
        end
        if (i_rdata_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", o_rdata, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("rdata", o_rdata, e[31:0]);
            chk("rdata_last", o_rdata_last, {31'd0, e[32]});
          end
          hs++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_d  = o_rdata;
          held_l  = o_rdata_last;
        end
      end
      step();
    end
    i_rdata_ready = 1'b0;
    chk("handshakes", hs, 32'd16);
  endtask

  task automatic after_fill();
    @(negedge clk);
    chk("req_ready_after_fill", o_req_ready, 32'd1);
    chk("rdata_valid_after_fill", o_rdata_valid, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    i_req_valid = 1'b0; i_req_write = 1'b0; i_req_address = '0;
    i_wdata_valid = 1'b0; i_wdata = '0; i_rdata_ready = 1'b0;
    for (int i = 0; i < 4096; i++) model_mem[i] = '0;

    // Reset held three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", o_req_ready, 32'd0);
    chk("rst_busy", o_busy, 32'd0);
    chk("rst_rdata_valid", o_rdata_valid, 32'd0);
    chk("rst_rdata_last", o_rdata_last, 32'd0);
    chk("rst_wdata_ready", o_wdata_ready, 32'd0);
    chk("rst_wr_done", o_wr_done, 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("req_ready_after_rst", o_req_ready, 32'd1);
    chk("busy_after_rst", o_busy, 32'd0);

    // Writeback then fill of the same line
    write_line(32'h0000_1240, 32'h0000_00A0, 3);
    issue_fill(32'h0000_1240);
    step();
    i_req_valid = 1'b0;
    collect(4'b1111, 1'b1, 1'b0);
    after_fill();

    // Back-pressure 1,0,0,1
    issue_fill(32'h0000_1240);
    step();
    i_req_valid = 1'b0;
    collect(4'b1001, 1'b1, 1'b0);
    after_fill();

    // Offset bits ignored; top line of the store and address wrap
    issue_fill(32'h0000_127F);
    step();
    i_req_valid = 1'b0;
    collect(4'b1111, 1'b1, 1'b0);
    after_fill();
    write_line(32'h0000_3FC0, 32'h5000_0000, -1);
    issue_fill(32'hFFFF_FFC0);
    step();
    i_req_valid = 1'b0;
    collect(4'b1111, 1'b1, 1'b0);
    after_fill();

    // Request held high during a fill is taken only after the last beat
    issue_fill(32'h0000_1240);
    step();
    issue_fill(32'h0000_3FC0);
    collect(4'b1111, 1'b1, 1'b1);
    @(negedge clk);
    chk("second_req_ready", o_req_ready, 32'd1);
    chk("second_req_busy", o_busy, 32'd0);
    step();
    i_req_valid = 1'b0;
    collect(4'b1111, 1'b1, 1'b0);
    after_fill();

    // Reset after writeback beat 5
    write_line(32'h0000_2000, 32'h0000_00B0, -1);
    @(negedge clk);
    i_req_valid = 1'b1; i_req_write = 1'b1; i_req_address = 32'h0000_2000;
    step();
    i_req_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      i_wdata_valid = 1'b1;
      i_wdata = 32'h0000_00C0 + k;
      model_mem[widx(32'h0000_2000, k)] = 32'h0000_00C0 + k;
      step();
    end
    i_wdata = 32'h0000_00C6;
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("midrst_wr_done", o_wr_done, 32'd0);
    chk("midrst_wdata_ready", o_wdata_ready, 32'd0);
    step();
    rst = 1'b1;
    i_wdata_valid = 1'b0;
    @(negedge clk);
    chk("midrst_idle_ready", o_req_ready, 32'd1);
    chk("midrst_idle_busy", o_busy, 32'd0);
    chk("midrst_no_done", o_wr_done, 32'd0);
    issue_fill(32'h0000_2000);
    step();
    i_req_valid = 1'b0;
    collect(4'b1111, 1'b1, 1'b0);
    after_fill();

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
